// File: rtl/rtr_vc_route_ctrl_pkg.sv
// Shared router constants: VC route-control state encoding and error-bit indices.
package rtr_vc_route_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_REQ    = 2'b01,
    ST_ACTIVE = 2'b10
  } vc_state_t;

  localparam int ERR_W           = 3;
  localparam int ERR_OVERFLOW    = 0;
  localparam int ERR_STRAY_GRANT = 1;
  localparam int ERR_STRAY_TAIL  = 2;

endpackage

// File: rtl/rtr_route_fifo.sv
// Purpose: small FIFO of lookahead head routes; head entry decoded combinationally, zero when empty.
// Latency: a push is visible at the head the cycle after it is written into an empty FIFO.
// Backpressure: push is dropped when full unless a pop frees a slot in the same cycle.
module rtr_route_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_dat,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign head_dat = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (do_pop && !do_push)
        count <= count - 1'b1;
    end
  end

  // When full with a same-cycle pop, the write lands in the slot being vacated.
  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/rtr_vc_route_ctrl.sv
// Purpose: per-input-VC route controller queuing lookahead routes and sequencing VC allocation.
// Latency: head accepted in cycle t raises route_valid in t+1; grant gives active the next cycle.
// Backpressure: route requests hold until granted; routes arriving at a full queue are dropped.
module rtr_vc_route_ctrl
  import rtr_vc_route_ctrl_pkg::*;
#(
  parameter int num_ports            = 5,
  parameter int num_resource_classes = 2,
  parameter int route_fifo_depth     = 2,
  parameter int port_id              = 0,
  parameter int vc_id                = 0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            head_valid,
  input  logic [num_ports-1:0]            head_op,
  input  logic [num_resource_classes-1:0] head_orc,
  input  logic                            alloc_grant,
  input  logic                            tail_sent,
  output logic                            route_valid,
  output logic [num_ports-1:0]            route_op,
  output logic [num_resource_classes-1:0] route_orc,
  output logic                            active,
  output logic [ERR_W-1:0]                errors
);

  localparam int RT_W  = num_ports + num_resource_classes;
  localparam int CNT_W = $clog2(route_fifo_depth + 1);

  vc_state_t        state;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic [RT_W-1:0]  fifo_head;
  logic [CNT_W-1:0] fifo_count;
  logic             push_acc;
  logic             overflow;
  logic             stray_grant;
  logic             stray_tail;
  logic             route_left;

  assign fifo_pop    = (state == ST_ACTIVE) && tail_sent;
  assign push_acc    = head_valid && (!fifo_full || fifo_pop);
  assign overflow    = head_valid && fifo_full && !fifo_pop;
  assign stray_grant = alloc_grant && (state != ST_REQ);
  assign stray_tail  = tail_sent && (state != ST_ACTIVE);
  // Another packet is waiting once the current route pops if more than one was
  // queued, or a new head arrives in the same cycle.
  assign route_left  = (fifo_count > CNT_W'(1)) || push_acc;

  rtr_route_fifo #(
    .WIDTH (RT_W),
    .DEPTH (route_fifo_depth)
  ) u_route_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (head_valid),
    .push_dat ({head_op, head_orc}),
    .pop      (fifo_pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head_dat (fifo_head),
    .count    (fifo_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      errors <= '0;
    end else begin
      errors[ERR_OVERFLOW]    <= overflow;
      errors[ERR_STRAY_GRANT] <= stray_grant;
      errors[ERR_STRAY_TAIL]  <= stray_tail;
      case (state)
        ST_IDLE:   if (push_acc || !fifo_empty) state <= ST_REQ;
        ST_REQ:    if (alloc_grant) state <= ST_ACTIVE;
        ST_ACTIVE: if (tail_sent) state <= route_left ? ST_REQ : ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  assign route_valid           = (state == ST_REQ);
  assign active                = (state == ST_ACTIVE);
  assign {route_op, route_orc} = fifo_head;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (errors[ERR_OVERFLOW])
      $display("%m: port %0d vc %0d: head route dropped, route queue full", port_id, vc_id);
    if (errors[ERR_STRAY_GRANT])
      $display("%m: port %0d vc %0d: alloc grant ignored, no request pending", port_id, vc_id);
    if (errors[ERR_STRAY_TAIL])
      $display("%m: port %0d vc %0d: tail ignored, no allocated output VC", port_id, vc_id);
  end
`endif

endmodule

// File: tb/tb_rtr_vc_route_ctrl.sv
// Scoreboarded bench: driver pushes reference-model expectations, negedge monitor compares outputs.
module tb_rtr_vc_route_ctrl;

  localparam int NP    = 5;
  localparam int NRC   = 2;
  localparam int DEPTH = 2;
  localparam int RT_W  = NP + NRC;

  typedef struct {
    int             cyc;
    logic           rv;
    logic [NP-1:0]  op;
    logic [NRC-1:0] orc;
    logic           act;
    logic [2:0]     err;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           head_valid = 1'b0;
  logic [NP-1:0]  head_op = '0;
  logic [NRC-1:0] head_orc = '0;
  logic           alloc_grant = 1'b0;
  logic           tail_sent = 1'b0;
  logic           route_valid;
  logic [NP-1:0]  route_op;
  logic [NRC-1:0] route_orc;
  logic           active;
  logic [2:0]     errors;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  exp_t            sb_q[$];
  logic [RT_W-1:0] mq[$];   // routes the VC still owes a packet for, oldest first
  logic            m_alloc = 1'b0;  // VC currently holds an output VC

  rtr_vc_route_ctrl #(
    .num_ports            (NP),
    .num_resource_classes (NRC),
    .route_fifo_depth     (DEPTH),
    .port_id              (0),
    .vc_id                (0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .head_valid  (head_valid),
    .head_op     (head_op),
    .head_orc    (head_orc),
    .alloc_grant (alloc_grant),
    .tail_sent   (tail_sent),
    .route_valid (route_valid),
    .route_op    (route_op),
    .route_orc   (route_orc),
    .active      (active),
    .errors      (errors)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural view: a request is outstanding whenever routes are queued and no
  // output VC is held; a tail releases the VC and retires its route.
  task automatic model_step(input logic hv, input logic [NP-1:0] op, input logic [NRC-1:0] orc,
                            input logic g, input logic t, output exp_t e);
    logic pop, req, ok;
    pop = m_alloc && t;
    req = !m_alloc && (mq.size() > 0);
    ok  = hv && ((mq.size() < DEPTH) || pop);
    e.err = {t && !m_alloc, g && !req, hv && !ok};
    if (pop) begin
      void'(mq.pop_front());
      m_alloc = 1'b0;
    end
    if (ok) mq.push_back({op, orc});
    if (g && req) m_alloc = 1'b1;
    e.rv  = !m_alloc && (mq.size() > 0);
    e.act = m_alloc;
    {e.op, e.orc} = (mq.size() > 0) ? mq[0] : '0;
  endtask

  task automatic drive(input logic hv, input logic [NP-1:0] op, input logic [NRC-1:0] orc,
                       input logic g, input logic t);
    exp_t e;
    head_valid = hv; head_op = op; head_orc = orc; alloc_grant = g; tail_sent = t;
    model_step(hv, op, orc, g, t, e);
    e.cyc = cyc + 1;
    sb_q.push_back(e);
  endtask

  task automatic step(input logic hv, input logic [NP-1:0] op, input logic [NRC-1:0] orc,
                      input logic g, input logic t);
    @(posedge clk); #1;
    drive(hv, op, orc, g, t);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_route_valid"}, route_valid, 0);
    chk({tag, "_route_op"}, route_op, 0);
    chk({tag, "_route_orc"}, route_orc, 0);
    chk({tag, "_active"}, active, 0);
    chk({tag, "_errors"}, errors, 0);
  endtask

  // Asynchronous reset mid-cycle; a head offered while reset is low must be ignored.
  task automatic reset_mid;
    exp_t e;
    @(posedge clk); #1;
    head_valid = 1'b1; head_op = 5'b10000; head_orc = 2'b10; alloc_grant = 1'b0; tail_sent = 1'b0;
    @(negedge clk); #1;
    reset = 1'b0;
    #1;
    chk_zero("async_reset");
    mq.delete();
    m_alloc = 1'b0;
    e.cyc = cyc + 1; e.rv = 0; e.op = '0; e.orc = '0; e.act = 0; e.err = '0;
    sb_q.push_back(e);
    @(posedge clk); #1;
    reset = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        e = sb_q.pop_front();
        if (e.cyc < cyc) begin
          chk("sb_stale", e.cyc, cyc);
        end else begin
          chk("route_valid", route_valid, e.rv);
          chk("route_op", route_op, e.op);
          chk("route_orc", route_orc, e.orc);
          chk("active", active, e.act);
          chk("errors", errors, e.err);
        end
      end
    end
  end

  initial begin : driver
    #2 reset = 1'b0;
    #1 chk_zero("power_on_reset");
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Head in IDLE -> request next cycle; grant after 3 held cycles; tail -> IDLE.
    step(1'b1, 5'b00100, 2'b01, 1'b0, 1'b0);
    idle(3);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    idle(2);

    // Second head pushed while active; tail hands straight over to REQ.
    step(1'b1, 5'b00010, 2'b10, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b1, 5'b01000, 2'b01, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    idle(1);

    // Three heads into a depth-2 queue: third dropped with a single overflow pulse.
    step(1'b1, 5'b00001, 2'b01, 1'b0, 1'b0);
    step(1'b1, 5'b00010, 2'b10, 1'b0, 1'b0);
    step(1'b1, 5'b10000, 2'b01, 1'b0, 1'b0);
    idle(2);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    idle(1);

    // Stray grant in IDLE, stray tail in REQ.
    step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b1, 5'b00100, 2'b10, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1);

    // Full queue with same-cycle pop and push: new route lands behind the survivor.
    step(1'b1, 5'b00001, 2'b01, 1'b0, 1'b0);
    step(1'b1, 5'b00010, 2'b01, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b1, 5'b01000, 2'b10, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    idle(1);

    // Reset while active with two routes queued.
    step(1'b1, 5'b00100, 2'b01, 1'b0, 1'b0);
    step(1'b1, 5'b01000, 2'b10, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    reset_mid();
    idle(2);

    for (int i = 0; i < 3000; i++) begin
      logic [NP-1:0]  op;
      logic [NRC-1:0] orc;
      op  = NP'(1) << $urandom_range(0, NP - 1);
      orc = NRC'(1) << $urandom_range(0, NRC - 1);
      if (i % 700 == 699)
        reset_mid();
      else
        step(($urandom_range(0, 99) < 30), op, orc,
             ($urandom_range(0, 99) < 35), ($urandom_range(0, 99) < 30));
    end

    idle(3);
    repeat (3) @(posedge clk);
    #1 chk("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rtr_vc_route_ctrl.md
RTR_VC_ROUTE_CTRL -- requirements
Module: rtr_vc_route_ctrl

Interface
REQ-001 SHALL have parameters: num_ports, default 5, router port count.
REQ-002 SHALL have parameters: num_resource_classes, default 2, resource classes per message class.
REQ-003 SHALL have parameters: route_fifo_depth, default 2, queued head routes per VC.
REQ-004 SHALL have parameters: port_id, default 0, input port ID.
REQ-005 SHALL have parameters: vc_id, default 0, input VC ID.
REQ-006 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-007 SHALL have ports: reset  in  1  asynchronous, active-low.
REQ-008 SHALL have ports: head_valid  in  1  head flit written to this VC's buffer.
REQ-009 SHALL have ports: head_op  in  num_ports  one-hot lookahead output port of that head.
REQ-010 SHALL have ports: head_orc  in  num_resource_classes  one-hot resource class of that head.
REQ-011 SHALL have ports: alloc_grant  in  1  VC allocator grant for this VC.
REQ-012 SHALL have ports: tail_sent  in  1  tail flit of current packet left the switch.
REQ-013 SHALL have ports: route_valid  out  1  route qualifier to route filter; equals alloc request.
REQ-014 SHALL have ports: route_op  out  num_ports  FIFO-head output port.
REQ-015 SHALL have ports: route_orc  out  num_resource_classes  FIFO-head resource class.
REQ-016 SHALL have ports: active  out  1  VC holds an allocated output VC.
REQ-017 SHALL have ports: errors  out  3  [0] route overflow, [1] stray grant, [2] stray tail.

Function
REQ-018 SHALL implement states IDLE, REQ, ACTIVE; all outputs registered or decoded from registered state.
REQ-019 SHALL push {head_op, head_orc} into the route FIFO on head_valid; route_op/route_orc SHALL show the FIFO head entry, all-zero when empty.
REQ-020 IDLE: FIFO non-empty -> REQ; so a head accepted in cycle t gives route_valid=1 in cycle t+1.
REQ-021 REQ: route_valid=1; alloc_grant -> ACTIVE next cycle; without grant stay in REQ, route held stable.
REQ-022 ACTIVE: active=1, route_valid=0; tail_sent pops FIFO.
REQ-023 ACTIVE with tail_sent: next state REQ if the FIFO holds at least one entry after the pop (counting a same-cycle push); otherwise IDLE.
REQ-024 Simultaneous push and pop SHALL leave the count unchanged, with the pushed entry ordered behind the remaining entries.
REQ-025 head_valid with FIFO full and no same-cycle pop SHALL drop the route, leave the FIFO unchanged, and pulse errors[0] for 1 cycle.
REQ-026 alloc_grant outside REQ SHALL be ignored and SHALL pulse errors[1].
REQ-027 tail_sent outside ACTIVE SHALL be ignored and SHALL pulse errors[2].
REQ-028 errors SHALL be registered one-cycle pulses; under synthesis-off guards each error SHALL print a $display naming %m.
REQ-029 FIFO count width SHALL be clog2(route_fifo_depth+1); pointers SHALL wrap modulo depth.

Reset
REQ-030 While reset=0, asynchronously: state=IDLE, FIFO empty, route_valid=0, route_op=0, route_orc=0, active=0, errors=0.
REQ-031 Reset mid-packet SHALL discard all queued routes; inputs are ignored until the first rising clk edge after reset deasserts.

Structure
REQ-032 State encodings (IDLE=2'b00, REQ=2'b01, ACTIVE=2'b10) and error-bit indices SHALL live in the shared router constants package.
REQ-033 The FIFO SHALL be a sub-module rtr_route_fifo (parameterised width/depth, push, pop, full, empty, head data).

Verification
REQ-034 Test: num_ports=5, head_valid with op=5'b00100, orc=2'b01 in IDLE -> route_valid=1, route_op=5'b00100 next cycle.
REQ-035 Test: REQ, grant after 3 idle cycles -> route held 3 cycles; active=1 the cycle after grant; tail_sent -> IDLE, route_valid=0.
REQ-036 Test: during ACTIVE push second head op=5'b01000; tail_sent -> REQ next cycle with route_op=5'b01000.
REQ-037 Test: depth=2, three heads with no pops -> third dropped, errors[0] pulses once, count stays 2.
REQ-038 Test: alloc_grant in IDLE -> errors[1] pulse, no state change; tail_sent in REQ -> errors[2] pulse.
REQ-039 Test: assert reset during ACTIVE with 2 queued routes -> all outputs 0 immediately; after release, state IDLE and FIFO empty.
